sa_ram_fifo_ctrl_128x257: RTL and testbench



---
 rtl/sa_ram_fifo_ctrl_128x257_if.sv | 29 ++
 rtl/sa_ram_fifo_ctrl_128x257.sv | 129 ++++++++++++
 tb/tb_sa_ram_fifo_ctrl_128x257.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sa_ram_fifo_ctrl_128x257_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | sa_ram_fifo_ctrl_128x257_if                                              |
// | Producer/consumer ready-valid channels of the RAM-backed FIFO controller.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface sa_ram_fifo_ctrl_128x257_if #(
  parameter int DW = 257
);
  logic          wr_pvld;
  logic          wr_prdy;
  logic [DW-1:0] wr_pd;
  logic          rd_pvld;
  logic          rd_prdy;
  logic [DW-1:0] rd_pd;

  // master is the side that pushes into and pops from the FIFO
  modport master (
    output wr_pvld, wr_pd, rd_prdy,
    input  wr_prdy, rd_pvld, rd_pd
  );

  modport slave (
    input  wr_pvld, wr_pd, rd_prdy,
    output wr_prdy, rd_pvld, rd_pd
  );
endinterface
`default_nettype wire

// File: rtl/sa_ram_fifo_ctrl_128x257.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | sa_ram_fifo_ctrl_128x257                                                 |
// | Pointer/issue control turning an external 2-stage-read RAM into a FIFO.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sa_ram_fifo_ctrl_128x257 #(
  parameter int DW         = 257,
  parameter int AW         = 7,
  parameter int DEPTH      = 128,
  parameter int OBUF_DEPTH = 4
) (
  input  wire logic                 clk,
  input  wire logic                 reset_,
  sa_ram_fifo_ctrl_128x257_if.slave io,
  output logic [AW-1:0]             ram_wa,
  output logic                      ram_we,
  output logic [DW-1:0]             ram_di,
  output logic [AW-1:0]             ram_ra,
  output logic                      ram_re,
  output logic                      ram_ore,
  input  wire logic [DW-1:0]        ram_dout,
  output logic [AW+1:0]             fifo_count,
  output logic                      idle
);

  localparam int              OBW       = $clog2(OBUF_DEPTH);
  localparam int              CW        = AW + 2;
  localparam logic [AW:0]     RAM_FULL  = DEPTH[AW:0];
  localparam logic [OBW:0]    OBUF_FULL = OBUF_DEPTH[OBW:0];

  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [AW:0]    ram_cnt_q, ram_cnt_d;
  logic           v1_q, v1_d;
  logic           v2_q, v2_d;
  logic [OBW-1:0] obuf_wp_q, obuf_wp_d;
  logic [OBW-1:0] obuf_rp_q, obuf_rp_d;
  logic [OBW:0]   obuf_cnt_q, obuf_cnt_d;
  logic [DW-1:0]  obuf_mem_q [OBUF_DEPTH];
  logic [DW-1:0]  obuf_mem_d [OBUF_DEPTH];

  logic [OBW+1:0] pend;
  logic           wr_rdy;
  logic           rd_vld;
  logic           push;
  logic           issue;
  logic           pop;

  always_comb begin
    wr_rdy = (ram_cnt_q != RAM_FULL);
    push   = io.wr_pvld & wr_rdy;

    // Reads already in the pipe reserve their skid slot, so a capture never overflows
    pend  = {1'b0, obuf_cnt_q}
          + {{(OBW + 1){1'b0}}, v1_q}
          + {{(OBW + 1){1'b0}}, v2_q};
    issue = (ram_cnt_q != '0) && (pend < {1'b0, OBUF_FULL});

    rd_vld = (obuf_cnt_q != '0);
    pop    = rd_vld & io.rd_prdy;

    wptr_d    = wptr_q + {{(AW - 1){1'b0}}, push};
    rptr_d    = rptr_q + {{(AW - 1){1'b0}}, issue};
    ram_cnt_d = ram_cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, issue};

    v1_d = issue;
    v2_d = v1_q;

    obuf_wp_d  = obuf_wp_q + {{(OBW - 1){1'b0}}, v2_q};
    obuf_rp_d  = obuf_rp_q + {{(OBW - 1){1'b0}}, pop};
    obuf_cnt_d = obuf_cnt_q + {{OBW{1'b0}}, v2_q} - {{OBW{1'b0}}, pop};

    obuf_mem_d = obuf_mem_q;
    if (v2_q) begin
      obuf_mem_d[obuf_wp_q] = ram_dout;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_cnt_q  <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      obuf_wp_q  <= '0;
      obuf_rp_q  <= '0;
      obuf_cnt_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ram_cnt_q  <= ram_cnt_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      obuf_wp_q  <= obuf_wp_d;
      obuf_rp_q  <= obuf_rp_d;
      obuf_cnt_q <= obuf_cnt_d;
    end
  end

  // Skid payload needs no reset: occupancy is tracked by obuf_cnt_q alone
  always_ff @(posedge clk) begin
    obuf_mem_q <= obuf_mem_d;
  end

  assign ram_we  = push;
  assign ram_wa  = wptr_q;
  assign ram_di  = io.wr_pd;
  assign ram_re  = issue;
  assign ram_ra  = rptr_q;
  assign ram_ore = v1_q;

  assign io.wr_prdy = wr_rdy;
  assign io.rd_pvld = rd_vld;
  assign io.rd_pd   = obuf_mem_q[obuf_rp_q];

  assign fifo_count = {1'b0, ram_cnt_q}
                    + {{(CW - 1){1'b0}}, v1_q}
                    + {{(CW - 1){1'b0}}, v2_q}
                    + {{(CW - OBW - 1){1'b0}}, obuf_cnt_q};
  assign idle = (fifo_count == '0) && !v1_q && !v2_q;

  a_obuf_bound: assert property (@(posedge clk) disable iff (!reset_)
                                 obuf_cnt_q <= OBUF_FULL);

endmodule
`default_nettype wire

// File: tb/tb_sa_ram_fifo_ctrl_128x257.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_sa_ram_fifo_ctrl_128x257                                              |
// | Directed bench with a behavioural 2-stage-read RAM beside the controller.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sa_ram_fifo_ctrl_128x257;
  localparam int DW = 257;
  localparam int AW = 7;

  logic clk    = 1'b0;
  logic reset_ = 1'b1;
  always #5 clk = ~clk;

  sa_ram_fifo_ctrl_128x257_if #(.DW(DW)) io ();

  logic [AW-1:0] ram_wa, ram_ra;
  logic          ram_we, ram_re, ram_ore;
  logic [DW-1:0] ram_di, ram_dout;
  logic [AW+1:0] fifo_count;
  logic          idle;

  sa_ram_fifo_ctrl_128x257 dut (
    .clk        (clk),
    .reset_     (reset_),
    .io         (io),
    .ram_wa     (ram_wa),
    .ram_we     (ram_we),
    .ram_di     (ram_di),
    .ram_ra     (ram_ra),
    .ram_re     (ram_re),
    .ram_ore    (ram_ore),
    .ram_dout   (ram_dout),
    .fifo_count (fifo_count),
    .idle       (idle)
  );

  // Two-port RAM: registered read address, registered output, synchronous write
  logic [DW-1:0] mem [128];
  logic [AW-1:0] ra_r;
  logic [DW-1:0] dout_r;
  always @(posedge clk) begin
    if (ram_we)  mem[ram_wa] <= ram_di;
    if (ram_re)  ra_r        <= ram_ra;
    if (ram_ore) dout_r      <= mem[ra_r];
  end
  assign ram_dout = dout_r;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q [$];

  function automatic logic [DW-1:0] word_of(input int i);
    logic [31:0] v;
    v = i;
    return {v[0], {8{v ^ 32'h5A00_0000}}};
  endfunction

  function automatic logic [DW-1:0] rand_word();
    return {1'($urandom), $urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock cycle: drive, sample the handshake just after, end on next negedge
  task automatic step(input logic pv, input logic [DW-1:0] pd, input logic rr,
                      output logic pushed, output logic popped,
                      output logic [DW-1:0] pdata);
    io.wr_pvld = pv;
    io.wr_pd   = pd;
    io.rd_prdy = rr;
    #1;
    pushed = pv & io.wr_prdy;
    popped = io.rd_pvld & rr;
    pdata  = io.rd_pd;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    io.wr_pvld = 1'b0;
    io.wr_pd   = '0;
    io.rd_prdy = 1'b0;
    reset_     = 1'b0;
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    io.wr_pvld = 1'b0;
    io.wr_pd   = '0;
    io.rd_prdy = 1'b0;
    #1 reset_ = 1'b0;
    #1;
    checks++; if (io.rd_pvld !== 1'b0) begin failures++; $display("FAIL reset_rd_pvld got=%0b want=0", io.rd_pvld); end
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_we got=%0b want=0", ram_we); end
    checks++; if (ram_re !== 1'b0) begin failures++; $display("FAIL reset_ram_re got=%0b want=0", ram_re); end
    checks++; if (ram_ore !== 1'b0) begin failures++; $display("FAIL reset_ram_ore got=%0b want=0", ram_ore); end
    checks++; if (fifo_count !== 9'd0) begin failures++; $display("FAIL reset_fifo_count got=%0d want=0", fifo_count); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%0b want=1", idle); end
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    #1;
    checks++; if (io.wr_prdy !== 1'b1) begin failures++; $display("FAIL reset_wr_prdy got=%0b want=1", io.wr_prdy); end
    @(negedge clk);
  endtask

  task automatic test_single_push();
    logic [DW-1:0] val;
    val = {1'b1, {64{4'hA}}};
    io.wr_pvld = 1'b1;
    io.wr_pd   = val;
    io.rd_prdy = 1'b0;
    #1;
    checks++; if (ram_we !== 1'b1 || ram_wa !== 7'd0) begin failures++; $display("FAIL single_write got we=%0b wa=%0d want we=1 wa=0", ram_we, ram_wa); end
    checks++; if (ram_di !== val) begin failures++; $display("FAIL single_ram_di got=%h want=%h", ram_di, val); end
    @(negedge clk);
    io.wr_pvld = 1'b0;
    #1;
    checks++; if (ram_re !== 1'b1 || ram_ra !== 7'd0) begin failures++; $display("FAIL single_issue got re=%0b ra=%0d want re=1 ra=0", ram_re, ram_ra); end
    @(negedge clk);
    #1;
    checks++; if (ram_ore !== 1'b1 || ram_re !== 1'b0) begin failures++; $display("FAIL single_ore got ore=%0b re=%0b want ore=1 re=0", ram_ore, ram_re); end
    @(negedge clk);
    #1;
    checks++; if (io.rd_pvld !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%0b want=0", io.rd_pvld); end
    @(negedge clk);
    #1;
    checks++; if (io.rd_pvld !== 1'b1) begin failures++; $display("FAIL single_valid_w4 got=%0b want=1", io.rd_pvld); end
    checks++; if (io.rd_pd !== val) begin failures++; $display("FAIL single_data got=%h want=%h", io.rd_pd, val); end
    checks++; if (fifo_count !== 9'd1) begin failures++; $display("FAIL single_count got=%0d want=1", fifo_count); end
    io.rd_prdy = 1'b1;
    @(negedge clk);
    io.rd_prdy = 1'b0;
    #1;
    checks++; if (idle !== 1'b1 || io.rd_pvld !== 1'b0) begin failures++; $display("FAIL single_idle got idle=%0b vld=%0b want idle=1 vld=0", idle, io.rd_pvld); end
  endtask

  task automatic test_stream();
    int wi = 0, ri = 0, cyc = 0, first = -1;
    logic pu, po;
    logic [DW-1:0] pdv;
    while (ri < 1000 && cyc < 1200) begin
      step(logic'(wi < 1000), word_of(wi), 1'b1, pu, po, pdv);
      if (pu) wi++;
      if (first >= 0) begin
        checks++; if (!po) begin failures++; $display("FAIL stream_bubble cycle=%0d got pop=0 want pop=1", cyc); end
      end
      if (po) begin
        checks++; if (pdv !== word_of(ri)) begin failures++; $display("FAIL stream_data idx=%0d got=%h want=%h", ri, pdv, word_of(ri)); end
        if (first < 0) first = cyc;
        ri++;
      end
      cyc++;
    end
    checks++; if (ri != 1000) begin failures++; $display("FAIL stream_count got=%0d want=1000", ri); end
    checks++; if (first != 4) begin failures++; $display("FAIL stream_latency got=%0d want=4", first); end
    #1;
    checks++; if (ram_wa !== 7'd105 || ram_ra !== 7'd105) begin failures++; $display("FAIL stream_wrap got wa=%0d ra=%0d want 105/105", ram_wa, ram_ra); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL stream_idle got=%0b want=1", idle); end
  endtask

  task automatic test_backpressure();
    int acc = 0, got = 0;
    logic pu, po, reup;
    logic [DW-1:0] pdv, e;
    apply_reset();
    for (int c = 0; c < 140; c++) begin
      step(1'b1, word_of(2000 + acc), 1'b0, pu, po, pdv);
      if (pu) begin exp_q.push_back(word_of(2000 + acc)); acc++; end
    end
    #1;
    checks++; if (acc != 132) begin failures++; $display("FAIL bp_accepted got=%0d want=132", acc); end
    checks++; if (io.wr_prdy !== 1'b0) begin failures++; $display("FAIL bp_wr_prdy got=%0b want=0", io.wr_prdy); end
    checks++; if (fifo_count !== 9'd132) begin failures++; $display("FAIL bp_fifo_count got=%0d want=132", fifo_count); end
    checks++; if (dut.ram_cnt_q !== 8'd128) begin failures++; $display("FAIL bp_ram_cnt got=%0d want=128", dut.ram_cnt_q); end
    checks++; if (io.rd_pvld !== 1'b1 || io.rd_pd !== word_of(2000)) begin failures++; $display("FAIL bp_head got vld=%0b pd=%h want vld=1 pd=%h", io.rd_pvld, io.rd_pd, word_of(2000)); end
    reup = 1'b0;
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
      step(1'b0, '0, 1'b1, pu, po, pdv);
      if (io.wr_prdy === 1'b1) reup = 1'b1;
      if (po) begin
        e = exp_q.pop_front();
        checks++; if (pdv !== e) begin failures++; $display("FAIL bp_data idx=%0d got=%h want=%h", got, pdv, e); end
        got++;
      end
    end
    #1;
    checks++; if (got != 132) begin failures++; $display("FAIL bp_drained got=%0d want=132", got); end
    checks++; if (reup !== 1'b1) begin failures++; $display("FAIL bp_wr_prdy_back got=%0b want=1", reup); end
    checks++; if (fifo_count !== 9'd0 || idle !== 1'b1) begin failures++; $display("FAIL bp_empty got count=%0d idle=%0b want 0/1", fifo_count, idle); end
  endtask

  task automatic test_slot_reuse();
    int n = 0, hits = 0;
    logic pu, po, cur_re, prev_re;
    logic [AW-1:0] cur_ra, cur_wa, prev_ra;
    logic [DW-1:0] pdv, e;
    apply_reset();
    for (int c = 0; c < 140; c++) begin
      step(1'b1, word_of(4000 + n), 1'b0, pu, po, pdv);
      if (pu) begin exp_q.push_back(word_of(4000 + n)); n++; end
    end
    n = 0;
    prev_re = 1'b0;
    prev_ra = '0;
    for (int c = 0; c < 300; c++) begin
      cur_re = ram_re;
      cur_ra = ram_ra;
      cur_wa = ram_wa;
      step(1'b1, word_of(5000 + n), 1'b1, pu, po, pdv);
      if (po) begin
        e = exp_q.pop_front();
        checks++; if (pdv !== e) begin failures++; $display("FAIL reuse_data cycle=%0d got=%h want=%h", c, pdv, e); end
      end
      if (pu) begin
        if (prev_re && cur_wa == prev_ra) hits++;
        exp_q.push_back(word_of(5000 + n));
        n++;
      end
      prev_re = cur_re;
      prev_ra = cur_ra;
    end
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
      step(1'b0, '0, 1'b1, pu, po, pdv);
      if (po) begin
        e = exp_q.pop_front();
        checks++; if (pdv !== e) begin failures++; $display("FAIL reuse_drain got=%h want=%h", pdv, e); end
      end
    end
    #1;
    checks++; if (hits < 200) begin failures++; $display("FAIL reuse_hits got=%0d want>=200", hits); end
    checks++; if (exp_q.size() != 0 || idle !== 1'b1) begin failures++; $display("FAIL reuse_empty got left=%0d idle=%0b want 0/1", exp_q.size(), idle); end
  endtask

  task automatic test_random();
    logic pu, po, pv, rr, cur_vld, prev_stall;
    logic [DW-1:0] pdv, d, e, cur_pd, prev_pd;
    apply_reset();
    prev_stall = 1'b0;
    prev_pd    = '0;
    for (int c = 0; c < 10000; c++) begin
      pv = ($urandom_range(0, 1) == 1);
      rr = ($urandom_range(0, 9) < 3);
      d  = rand_word();
      cur_vld = io.rd_pvld;
      cur_pd  = io.rd_pd;
      checks++; if (int'(fifo_count) != exp_q.size()) begin failures++; $display("FAIL rand_count cycle=%0d got=%0d want=%0d", c, fifo_count, exp_q.size()); end
      checks++; if (dut.obuf_cnt_q > 4) begin failures++; $display("FAIL rand_obuf_bound cycle=%0d got=%0d want<=4", c, dut.obuf_cnt_q); end
      if (prev_stall) begin
        checks++; if (cur_vld !== 1'b1 || cur_pd !== prev_pd) begin failures++; $display("FAIL rand_stall cycle=%0d got vld=%0b pd=%h want pd=%h", c, cur_vld, cur_pd, prev_pd); end
      end
      step(pv, d, rr, pu, po, pdv);
      if (pu) exp_q.push_back(d);
      if (po) begin
        if (exp_q.size() == 0) begin
          checks++; failures++; $display("FAIL rand_underflow cycle=%0d got=%h want=none", c, pdv);
        end else begin
          e = exp_q.pop_front();
          checks++; if (pdv !== e) begin failures++; $display("FAIL rand_data cycle=%0d got=%h want=%h", c, pdv, e); end
        end
      end
      prev_stall = cur_vld && !rr;
      prev_pd    = cur_pd;
    end
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
      step(1'b0, '0, 1'b1, pu, po, pdv);
      if (po) begin
        e = exp_q.pop_front();
        checks++; if (pdv !== e) begin failures++; $display("FAIL rand_drain got=%h want=%h", pdv, e); end
      end
    end
    #1;
    checks++; if (exp_q.size() != 0 || idle !== 1'b1) begin failures++; $display("FAIL rand_empty got left=%0d idle=%0b want 0/1", exp_q.size(), idle); end
  endtask

  task automatic test_midreset();
    logic pu, po, act;
    logic [DW-1:0] pdv, w;
    apply_reset();
    for (int c = 0; c < 5; c++) step(1'b1, word_of(9000 + c), 1'b0, pu, po, pdv);
    io.wr_pvld = 1'b0;
    #1;
    checks++; if (dut.v1_q !== 1'b1 || dut.v2_q !== 1'b1 || dut.obuf_cnt_q !== 3'd2) begin failures++; $display("FAIL mid_precond got v1=%0b v2=%0b obuf=%0d want 1/1/2", dut.v1_q, dut.v2_q, dut.obuf_cnt_q); end
    reset_ = 1'b0;
    #1;
    checks++; if (io.rd_pvld !== 1'b0 || ram_ore !== 1'b0 || ram_re !== 1'b0 || ram_we !== 1'b0) begin failures++; $display("FAIL mid_outputs got vld=%0b ore=%0b re=%0b we=%0b want 0", io.rd_pvld, ram_ore, ram_re, ram_we); end
    checks++; if (fifo_count !== 9'd0 || idle !== 1'b1 || io.wr_prdy !== 1'b1) begin failures++; $display("FAIL mid_state got count=%0d idle=%0b prdy=%0b want 0/1/1", fifo_count, idle, io.wr_prdy); end
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    act = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (ram_re === 1'b1 || ram_ore === 1'b1 || io.rd_pvld === 1'b1) act = 1'b1;
      @(negedge clk);
    end
    checks++; if (act !== 1'b0) begin failures++; $display("FAIL mid_quiet got activity=%0b want=0", act); end
    w = {1'b0, {64{4'h3}}};
    io.wr_pvld = 1'b1;
    io.wr_pd   = w;
    #1;
    checks++; if (ram_we !== 1'b1 || ram_wa !== 7'd0) begin failures++; $display("FAIL mid_write got we=%0b wa=%0d want we=1 wa=0", ram_we, ram_wa); end
    @(negedge clk);
    io.wr_pvld = 1'b0;
    for (int c = 0; c < 10 && io.rd_pvld !== 1'b1; c++) @(negedge clk);
    #1;
    checks++; if (io.rd_pvld !== 1'b1 || io.rd_pd !== w) begin failures++; $display("FAIL mid_first_out got vld=%0b pd=%h want pd=%h", io.rd_pvld, io.rd_pd, w); end
    io.rd_prdy = 1'b1;
    @(negedge clk);
    io.rd_prdy = 1'b0;
    #1;
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL mid_idle got=%0b want=1", idle); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_stream();
    test_backpressure();
    test_slot_reuse();
    test_random();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
